// File: rtl/note_capture_pkg.sv
// note_capture_pkg: shared widths, note codes, FSM encodings and helper
// functions for the note capture block (debounce, timestamp, length code).
package note_capture_pkg;

  localparam int CLOCK_BITS     = 21;
  localparam int OCTAVE_BITS    = 2;
  localparam int NOTE_BITS      = 3;
  localparam int LENGTH_BITS    = 3;
  localparam int KEY_COUNT      = 7;
  localparam int DEBOUNCE_TICKS = 4;
  localparam int UNIT_TICKS     = 32;
  localparam int HOLD_BITS      = 12;
  localparam int MAX_LENGTH     = (1 << LENGTH_BITS) - 1;
  // Hold length at which the top length code is reached (2048 by default).
  localparam int AUTO_RELEASE_TICKS = UNIT_TICKS << ((1 << LENGTH_BITS) - 2);

  localparam logic [NOTE_BITS-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS     = 2'd1,
    ST_EMIT      = 2'd2,
    ST_HOLD_WAIT = 2'd3
  } state_t;

  // Lowest set key wins; code = index + 1, empty vector = rest.
  function automatic logic [NOTE_BITS-1:0] note_code(input logic [KEY_COUNT-1:0] v);
    note_code = NOTE_REST;
    for (int i = KEY_COUNT - 1; i >= 0; i--)
      if (v[i]) note_code = NOTE_BITS'(i + 1);
  endfunction

  // floor(log2(h / UNIT_TICKS)) + 1, zero below one unit, saturating.
  function automatic logic [LENGTH_BITS-1:0] quantize_length(input logic [HOLD_BITS-1:0] h);
    logic [HOLD_BITS-1:0] units;
    units = h >> $clog2(UNIT_TICKS);
    quantize_length = '0;
    for (int b = 0; b < HOLD_BITS; b++)
      if (units[b]) begin
        if (b + 1 >= MAX_LENGTH) quantize_length = LENGTH_BITS'(MAX_LENGTH);
        else                     quantize_length = LENGTH_BITS'(b + 1);
      end
  endfunction

  // The press happened DEBOUNCE_TICKS before it was accepted; clamp at 0.
  function automatic logic [CLOCK_BITS-1:0] press_stamp(input logic [CLOCK_BITS-1:0] now);
    if (now < CLOCK_BITS'(DEBOUNCE_TICKS)) press_stamp = '0;
    else                                   press_stamp = now - CLOCK_BITS'(DEBOUNCE_TICKS);
  endfunction

endpackage

// File: rtl/note_capture_if.sv
// note_capture_if: valid/ready note event channel from capture to scorer.
interface note_capture_if;
  import note_capture_pkg::*;

  logic                   ev_valid;
  logic                   ev_ready;
  logic [CLOCK_BITS-1:0]  ev_clock;
  logic [OCTAVE_BITS-1:0] ev_octave;
  logic [NOTE_BITS-1:0]   ev_note;
  logic [LENGTH_BITS-1:0] ev_length;

  modport master (output ev_valid, ev_clock, ev_octave, ev_note, ev_length,
                  input  ev_ready);
  modport slave  (input  ev_valid, ev_clock, ev_octave, ev_note, ev_length,
                  output ev_ready);
endinterface

// File: rtl/note_capture_key_debounce.sv
// key_debounce: accepts the raw key vector once it has been identical for
// DEBOUNCE_TICKS consecutive game ticks; any change restarts the count.
module key_debounce
  import note_capture_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [KEY_COUNT-1:0] raw,
  output logic [KEY_COUNT-1:0] stable
);

  localparam int CNT_BITS = $clog2(DEBOUNCE_TICKS + 1);

  logic [KEY_COUNT-1:0] sample;
  logic [CNT_BITS-1:0]  run;

  // Stability counter: counts ticks on which raw matches the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every state register is cleared here; there is no memory array that would need to skip reset.
      sample <= '0;
      run    <= '0;
      stable <= '0;
    end else if (tick) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      if (raw != sample) begin
        sample <= raw;
        run    <= CNT_BITS'(1);
      end else begin
        if (run < CNT_BITS'(DEBOUNCE_TICKS)) run <= run + CNT_BITS'(1);
        if (run >= CNT_BITS'(DEBOUNCE_TICKS - 1)) stable <= sample;
      end
    end
  end

endmodule

// File: rtl/note_capture.sv
// note_capture: debounced key presses become timestamped, length-coded note
// events on a valid/ready channel. Optional macro NOTE_CAPTURE_AUTO_RELEASE_EN
// emits very long holds early and waits for release in ST_HOLD_WAIT.
module note_capture
  import note_capture_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic [CLOCK_BITS-1:0]  game_clock,
  input  logic                   enable,
  input  logic [KEY_COUNT-1:0]   keys,
  input  logic [OCTAVE_BITS-1:0] octave_sel,
  note_capture_if.master         ev,
  output logic [7:0]             dropped
);

  logic [KEY_COUNT-1:0]   deb;
  logic [NOTE_BITS-1:0]   code, prev_code, note_q;
  logic [OCTAVE_BITS-1:0] octave_q;
  logic [CLOCK_BITS-1:0]  clock_q;
  logic [LENGTH_BITS-1:0] length_q;
  logic [HOLD_BITS-1:0]   hold_cnt;
  logic                   auto_fire;
  state_t                 state, state_nx;

  key_debounce u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .raw    (keys),
    .stable (deb)
  );

  assign code = note_code(deb);

`ifdef NOTE_CAPTURE_AUTO_RELEASE_EN
  assign auto_fire = (hold_cnt >= HOLD_BITS'(AUTO_RELEASE_TICKS));
`else
  assign auto_fire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      ST_IDLE:  if (enable && code != NOTE_REST) state_nx = ST_PRESS;
      ST_PRESS: begin
        if (!enable)                           state_nx = ST_IDLE;
        else if (code != note_q || auto_fire)  state_nx = ST_EMIT;
      end
`ifdef NOTE_CAPTURE_AUTO_RELEASE_EN
      ST_EMIT:      if (ev.ev_ready) state_nx = ST_HOLD_WAIT;
      ST_HOLD_WAIT: if (code == NOTE_REST) state_nx = ST_IDLE;
`else
      ST_EMIT:      if (ev.ev_ready) state_nx = ST_IDLE;
`endif
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs: the event is offered for exactly the EMIT state.
  always_comb begin
    ev.ev_valid = (state == ST_EMIT);
  end

  assign ev.ev_clock  = clock_q;
  assign ev.ev_octave = octave_q;
  assign ev.ev_note   = note_q;
  assign ev.ev_length = length_q;

  // Event fields, hold counter and dropped-press counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code <= NOTE_REST;
      note_q    <= NOTE_REST;
      octave_q  <= '0;
      clock_q   <= '0;
      length_q  <= '0;
      hold_cnt  <= '0;
      dropped   <= '0;
    end else begin
      prev_code <= code;
      if (state == ST_IDLE && state_nx == ST_PRESS) begin
        note_q   <= code;
        octave_q <= octave_sel;
        clock_q  <= press_stamp(game_clock);
        hold_cnt <= '0;
      end else if (state == ST_PRESS && tick && hold_cnt != {HOLD_BITS{1'b1}}) begin
        hold_cnt <= hold_cnt + HOLD_BITS'(1);
      end
      if (state == ST_PRESS && state_nx == ST_EMIT)
        length_q <= quantize_length(hold_cnt);
      // A press arriving on the handshake cycle is picked up by IDLE, not lost.
      if (state == ST_EMIT && !ev.ev_ready && prev_code == NOTE_REST &&
          code != NOTE_REST && dropped != 8'hFF)
        dropped <= dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_note_capture.sv
// tb_note_capture: scoreboard bench for note_capture. Expected events are
// queued as presses are driven and compared when the DUT hands them over.
module tb_note_capture;
  import note_capture_pkg::*;

  typedef struct {
    logic [CLOCK_BITS-1:0]  clk_v;
    logic [OCTAVE_BITS-1:0] oct;
    logic [NOTE_BITS-1:0]   note;
    logic [LENGTH_BITS-1:0] len;
  } ev_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   tick = 1'b0;
  logic [CLOCK_BITS-1:0]  game_clock = '0;
  logic                   enable = 1'b1;
  logic [KEY_COUNT-1:0]   keys = '0;
  logic [OCTAVE_BITS-1:0] octave_sel = '0;
  logic [7:0]             dropped;

  note_capture_if ev_if ();

  note_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .game_clock (game_clock),
    .enable     (enable),
    .keys       (keys),
    .octave_sel (octave_sel),
    .ev         (ev_if),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  xfer_count = 0;
  int  exp_xfer = 0;
  bit  gc_run = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_len(input int h);
    if (h < UNIT_TICKS) return 0;
    for (int c = 1; c < 7; c++)
      if (h < (UNIT_TICKS << c)) return c;
    return 7;
  endfunction

  task automatic push_ev(input logic [CLOCK_BITS-1:0] c, input logic [NOTE_BITS-1:0] n, input int h);
    ev_t e;
    e.clk_v = c;
    e.oct   = octave_sel;
    e.note  = n;
    e.len   = LENGTH_BITS'(exp_len(h));
    sb.push_back(e);
    exp_xfer++;
  endtask

  // One game tick every four clocks; game_clock advances after the tick edge.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      if (gc_run) game_clock = game_clock + 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  // Hold k for n ticks, then release long enough for the event to drain.
  task automatic press(input logic [KEY_COUNT-1:0] k, input int n);
    keys = k;
    do_ticks(n);
    keys = '0;
    do_ticks(8);
  endtask

  // Monitor: every accepted transfer is popped and compared.
  always @(negedge clk) begin
    if (rst_n && ev_if.ev_valid && ev_if.ev_ready) begin
      ev_t e;
      xfer_count++;
      if (sb.size() == 0) begin
        check("spurious_ev", 32'(ev_if.ev_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ev_clock",  32'(ev_if.ev_clock),  32'(e.clk_v));
        check("ev_octave", 32'(ev_if.ev_octave), 32'(e.oct));
        check("ev_note",   32'(ev_if.ev_note),   32'(e.note));
        check("ev_length", 32'(ev_if.ev_length), 32'(e.len));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [CLOCK_BITS-1:0] t0, t1;
    ev_if.ev_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid",  32'(ev_if.ev_valid),  32'd0);
    check("rst_clock",  32'(ev_if.ev_clock),  32'd0);
    check("rst_note",   32'(ev_if.ev_note),   32'd0);
    check("rst_length", 32'(ev_if.ev_length), 32'd0);
    check("rst_octave", 32'(ev_if.ev_octave), 32'd0);
    check("rst_drop",   32'(dropped),         32'd0);
    rst_n = 1'b1;
    do_ticks(6);

    // Basic press: keys[2] at 1000, 100 ticks -> length 2.
    game_clock = 1000;
    octave_sel = 2'd2;
    push_ev(21'd1000, 3'd3, 100);
    press(7'h04, 100);
    check("xfer_basic", 32'(xfer_count), 32'(exp_xfer));

    // Two-tick glitch never passes the debouncer.
    keys = 7'h01;
    do_ticks(2);
    keys = '0;
    do_ticks(3);
    check("glitch_valid", 32'(ev_if.ev_valid), 32'd0);
    do_ticks(6);
    check("xfer_glitch", 32'(xfer_count), 32'(exp_xfer));

    // Short hold -> length 0.
    octave_sel = 2'd1;
    push_ev(game_clock, 3'd5, 10);
    press(7'h10, 10);
    check("xfer_short", 32'(xfer_count), 32'(exp_xfer));

    // Long hold of 3000 ticks -> length 7 (early emit with auto release).
    t0 = game_clock;
    base = xfer_count;
    push_ev(t0, 3'd5, 3000);
    keys = 7'h10;
    do_ticks(2100);
`ifdef NOTE_CAPTURE_AUTO_RELEASE_EN
    check("auto_early", 32'(xfer_count), 32'(base + 1));
`else
    check("no_early", 32'(xfer_count), 32'(base));
`endif
    do_ticks(900);
    keys = '0;
    do_ticks(8);
    check("xfer_long", 32'(xfer_count), 32'(exp_xfer));

    // Back-pressure: event held, two extra presses counted as dropped.
    ev_if.ev_ready = 1'b0;
    octave_sel = 2'd3;
    push_ev(game_clock, 3'd4, 40);
    press(7'h08, 40);
    check("bp_valid", 32'(ev_if.ev_valid), 32'd1);
    press(7'h02, 6);
    press(7'h40, 6);
    check("bp_dropped", 32'(dropped), 32'd2);
    check("bp_valid2",  32'(ev_if.ev_valid),  32'd1);
    check("bp_clock",   32'(ev_if.ev_clock),  32'(sb[0].clk_v));
    check("bp_note",    32'(ev_if.ev_note),   32'(sb[0].note));
    check("bp_length",  32'(ev_if.ev_length), 32'(sb[0].len));
    ev_if.ev_ready = 1'b1;
    do_ticks(2);
    check("bp_xfer",     32'(xfer_count),      32'(exp_xfer));
    check("bp_released", 32'(ev_if.ev_valid),  32'd0);
    check("bp_dropped2", 32'(dropped),         32'd2);

    // Two keys together, then slide to the higher one.
    octave_sel = 2'd0;
    t0 = game_clock;
    t1 = t0 + 21'd40;
    push_ev(t0, 3'd2, 40);
`ifndef NOTE_CAPTURE_AUTO_RELEASE_EN
    push_ev(t1, 3'd6, 70);
`endif
    keys = 7'h22;
    do_ticks(40);
    keys = 7'h20;
    do_ticks(70);
    keys = '0;
    do_ticks(8);
    check("xfer_slide", 32'(xfer_count), 32'(exp_xfer));

    // enable falling mid-press discards the press.
    keys = 7'h01;
    do_ticks(20);
    enable = 1'b0;
    do_ticks(4);
    keys = '0;
    do_ticks(8);
    enable = 1'b1;
    do_ticks(4);
    check("en_valid", 32'(ev_if.ev_valid), 32'd0);
    check("xfer_en",  32'(xfer_count),     32'(exp_xfer));

    // Timestamp saturates at 0 when the clock is below the debounce delay.
    gc_run = 1'b0;
    game_clock = 21'd1;
    octave_sel = 2'd2;
    push_ev(21'd0, 3'd3, 40);
    press(7'h04, 40);
    gc_run = 1'b1;
    check("xfer_sat", 32'(xfer_count), 32'(exp_xfer));

    // Reset while an event is pending drops it immediately.
    ev_if.ev_ready = 1'b0;
    press(7'h04, 40);
    check("emit_before_rst", 32'(ev_if.ev_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_emit_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_emit_note",  32'(ev_if.ev_note),  32'd0);
    check("rst_emit_drop",  32'(dropped),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ev_if.ev_ready = 1'b1;
    do_ticks(6);
    check("post_rst_valid", 32'(ev_if.ev_valid), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("xfer_final", 32'(xfer_count), 32'(exp_xfer));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
